// File: rtl/transaction_pkg.sv
// Shared FSM state encoding and constants
// for the coin transaction sequencer.
package transaction_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_P1,
    RD_P2,
    CHECK,
    WR_P1,
    WR_P2,
    DRAW,
    WAIT_FRAME,
    ERASE,
    DONE
  } state_t;

  localparam logic [2:0] COIN = 3'b110;
  localparam logic [2:0] BG   = 3'b000;

  localparam logic ADDR_P1 = 1'b0;
  localparam logic ADDR_P2 = 1'b1;

endpackage

// File: rtl/transaction_sequencer_if.sv
// Balance RAM bus plus VGA plot bus.
// master: sequencer side; slave: RAM / VGA side.
interface transaction_sequencer_if #(
  parameter int BAL_W = 8
);

  logic             mem_addr;
  logic [BAL_W-1:0] mem_rdata;
  logic [BAL_W-1:0] mem_wdata;
  logic             mem_we;
  logic             plot;
  logic [7:0]       x;
  logic [6:0]       y;
  logic [2:0]       colour;

  modport master (
    output mem_addr, mem_wdata, mem_we,
    output plot, x, y, colour,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_we,
    input  plot, x, y, colour,
    output mem_rdata
  );

endinterface

// File: rtl/coin_sprite_plotter.sv
// Walks a COIN_SIZE x COIN_SIZE square in raster order, one pixel per clock,
// while go is high. Ports: go/x0/y0/colour in; plot/x/y/pix_colour/done out.
module coin_sprite_plotter #(
  parameter int COIN_SIZE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [2:0] colour,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] pix_colour,
  output logic       done
);

  localparam int CW = $clog2(COIN_SIZE);

  logic [2*CW-1:0] idx;
  logic [CW-1:0]   row;
  logic [CW-1:0]   col;

  assign {row, col} = idx;
  assign done = go && (idx == '1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (!go || done) begin
      idx <= '0;
    end else begin
      idx <= idx + 1'b1;
    end
  end

  // Pixel outputs are forced to zero whenever nothing is being plotted.
  assign plot       = go;
  assign x          = go ? x0 + 8'(col) : '0;
  assign y          = go ? y0 + 7'(row) : '0;
  assign pix_colour = go ? colour : '0;

endmodule

// File: rtl/transaction_sequencer.sv
// Coin transaction: read P1/P2, validate, debit/credit, animate coin, pulse done.
// Ports: clock, reset, start_animation, amount, key, txn_ok,
// finished_transaction, bus (RAM + VGA). Optional macro TXN_FEE_EN adds FEE.
module transaction_sequencer
  import transaction_pkg::*;
#(
  parameter int               BAL_W     = 8,
  parameter int               KEY_W     = 4,
  parameter logic [KEY_W-1:0] VALID_KEY = 4'hA,
  parameter int               COIN_SIZE = 4,
  parameter int               X_START   = 16,
  parameter int               X_END     = 136,
  parameter int               Y_ROW     = 60,
  parameter int               STEP      = 4,
  parameter int               FRAME_DIV = 833333
`ifdef TXN_FEE_EN
  ,
  parameter int               FEE       = 1
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_animation,
  input  logic [BAL_W-1:0] amount,
  input  logic [KEY_W-1:0] key,
  output logic             txn_ok,
  output logic             finished_transaction,
  transaction_sequencer_if.master bus
);

  localparam int FW = $clog2(FRAME_DIV) + 1;

  state_t           state;
  state_t           state_n;
  logic             start_q;
  logic             start;
  logic [BAL_W-1:0] amt;
  logic [BAL_W-1:0] bal1;
  logic [BAL_W-1:0] bal2;
  logic [KEY_W-1:0] key_q;
  logic [7:0]       pos;
  logic [FW-1:0]    frame_cnt;
  logic [BAL_W:0]   sum2;
  logic [BAL_W:0]   debit;
  logic             ok;
  logic             go;
  logic             pdone;
  logic             frame_end;
  logic             last_pos;
  logic [2:0]       fill;

  assign start = start_animation & ~start_q;

  // Total taken from P1, one bit wider so the funds check cannot wrap.
`ifdef TXN_FEE_EN
  localparam logic [BAL_W:0] FEE_W = (BAL_W+1)'(FEE);
  assign debit = {1'b0, amt} + FEE_W;
`else
  assign debit = {1'b0, amt};
`endif

  // P2 balance is still on the read port while in CHECK.
  assign sum2 = {1'b0, bus.mem_rdata} + {1'b0, amt};

  assign ok = (key_q == VALID_KEY)
           && (debit <= {1'b0, bal1})
           && !sum2[BAL_W];

  assign frame_end = frame_cnt == FW'(FRAME_DIV - 1);
  assign last_pos  = ({1'b0, pos} + 9'(STEP)) > 9'(X_END);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      amt       <= '0;
      key_q     <= '0;
      bal1      <= '0;
      bal2      <= '0;
      pos       <= '0;
      frame_cnt <= '0;
      txn_ok    <= 1'b0;
    end else begin
      state   <= state_n;
      start_q <= start_animation;
      unique case (state)
        IDLE: begin
          if (start) begin
            amt    <= amount;
            key_q  <= key;
            txn_ok <= 1'b0;
          end
        end
        RD_P2: bal1 <= bus.mem_rdata;
        CHECK: begin
          bal2   <= bus.mem_rdata;
          txn_ok <= ok;
        end
        WR_P2: pos <= 8'(X_START);
        WAIT_FRAME: begin
          frame_cnt <= frame_end ? '0 : frame_cnt + FW'(1);
        end
        ERASE: begin
          if (pdone && !last_pos) pos <= pos + 8'(STEP);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n              = state;
    go                   = 1'b0;
    fill                 = BG;
    finished_transaction = 1'b0;
    bus.mem_addr         = ADDR_P1;
    bus.mem_we           = 1'b0;
    bus.mem_wdata        = '0;
    unique case (state)
      IDLE:  if (start) state_n = RD_P1;
      RD_P1: state_n = RD_P2;
      RD_P2: begin
        bus.mem_addr = ADDR_P2;
        state_n      = CHECK;
      end
      CHECK: state_n = ok ? WR_P1 : DONE;
      WR_P1: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bal1 - debit[BAL_W-1:0];
        state_n       = WR_P2;
      end
      WR_P2: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = ADDR_P2;
        bus.mem_wdata = bal2 + amt;
        state_n       = DRAW;
      end
      DRAW: begin
        go   = 1'b1;
        fill = COIN;
        if (pdone) state_n = WAIT_FRAME;
      end
      WAIT_FRAME: if (frame_end) state_n = ERASE;
      ERASE: begin
        go = 1'b1;
        if (pdone) state_n = last_pos ? DONE : DRAW;
      end
      DONE: begin
        finished_transaction = 1'b1;
        state_n              = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  coin_sprite_plotter #(
    .COIN_SIZE(COIN_SIZE)
  ) u_plotter (
    .clock      (clock),
    .reset      (reset),
    .go         (go),
    .x0         (pos),
    .y0         (7'(Y_ROW)),
    .colour     (fill),
    .plot       (bus.plot),
    .x          (bus.x),
    .y          (bus.y),
    .pix_colour (bus.colour),
    .done       (pdone)
  );

endmodule

// File: tb/tb_transaction_sequencer.sv
// Randomised + directed bench for transaction_sequencer
// against a transaction-level reference model.
module tb_transaction_sequencer;

`ifdef TXN_FEE_EN
  localparam int FEE_M = 1;
`else
  localparam int FEE_M = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start_animation = 1'b0;
  logic [7:0] amount = '0;
  logic [3:0] key = '0;
  logic       txn_ok;
  logic       finished_transaction;

  transaction_sequencer_if #(.BAL_W(8)) bus ();

  transaction_sequencer #(
    .FRAME_DIV(4),
    .X_START  (16),
    .X_END    (24)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .start_animation     (start_animation),
    .amount              (amount),
    .key                 (key),
    .txn_ok              (txn_ok),
    .finished_transaction(finished_transaction),
    .bus                 (bus)
  );

  always #5 clock = ~clock;

  // Two-entry balance RAM with one-clock read latency.
  logic [7:0] ram [2];
  logic       pre_en = 1'b0;
  logic [7:0] pre0 = '0;
  logic [7:0] pre1 = '0;

  always @(posedge clock) begin
    if (pre_en) begin
      ram[0] <= pre0;
      ram[1] <= pre1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Observed traffic, sampled mid-cycle.
  int          n_fin = 0;
  int          n_both = 0;
  logic [17:0] pq[$];
  logic [8:0]  wq[$];

  always @(negedge clock) begin
    if (finished_transaction) n_fin++;
    if (bus.plot) pq.push_back({bus.x, bus.y, bus.colour});
    if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});
    if (bus.plot && bus.mem_we) n_both++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic preload(input int b1, input int b2);
    pre0 = 8'(b1);
    pre1 = 8'(b2);
    pre_en = 1'b1;
    @(posedge clock);
    #1 pre_en = 1'b0;
  endtask

  task automatic clear_obs();
    pq.delete();
    wq.delete();
    n_fin = 0;
    n_both = 0;
  endtask

  task automatic outs_zero(input string tag);
    check(tag, {bus.mem_addr, bus.mem_we, bus.mem_wdata,
                bus.plot, bus.x, bus.y, bus.colour,
                txn_ok, finished_transaction}, 0);
  endtask

  task automatic run_txn(input int b1, input int b2,
                         input int a, input int k,
                         input bit hold, input bit pulse);
    int          cyc;
    bit          exp_ok;
    bit          pulsed;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [17:0] ep[$];
    logic [8:0]  ew[$];
    exp_ok = (k == 10) && (a + FEE_M <= b1) && (b2 + a <= 255);
    e1 = exp_ok ? 8'(b1 - a - FEE_M) : 8'(b1);
    e2 = exp_ok ? 8'(b2 + a) : 8'(b2);
    if (exp_ok) begin
      ew.push_back({1'b0, e1});
      ew.push_back({1'b1, e2});
      for (int p = 16; p <= 24; p += 4)
        for (int c = 0; c < 2; c++)
          for (int r = 0; r < 4; r++)
            for (int cl = 0; cl < 4; cl++)
              ep.push_back({8'(p + cl), 7'(60 + r),
                            (c == 0) ? 3'b110 : 3'b000});
    end
    preload(b1, b2);
    start_animation = 1'b0;
    amount = 8'(a);
    key = 4'(k);
    @(posedge clock);
    #1;
    clear_obs();
    start_animation = 1'b1;
    cyc = 0;
    pulsed = 1'b0;
    while (!finished_transaction && cyc < 400) begin
      @(posedge clock);
      #1;
      cyc++;
      if (pulse && bus.plot && !pulsed) begin
        start_animation = 1'b0;
        @(posedge clock);
        #1;
        cyc++;
        start_animation = 1'b1;
        pulsed = 1'b1;
      end
    end
    check("done_timeout", 32'(cyc < 400), 1);
    if (!exp_ok) check("reject_latency", cyc, 4);
    if (!hold) start_animation = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("txn_ok", txn_ok, exp_ok);
    check("fin_count", n_fin, 1);
    check("we_plot_overlap", n_both, 0);
    check("write_count", wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++)
      check("write", wq[i], ew[i]);
    check("plot_count", pq.size(), ep.size());
    for (int i = 0; i < ep.size() && i < pq.size(); i++)
      check("pixel", pq[i], ep[i]);
    check("ram_p1", ram[0], e1);
    check("ram_p2", ram[1], e2);
  endtask

  initial begin
    int cyc;
    int b1;
    int b2;
    int a;
    int k;

    #2;
    outs_zero("reset_outs");
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    outs_zero("idle_outs");

    run_txn(50, 20, 30, 10, 0, 0);
    run_txn(50, 20, 5, 3, 0, 0);
    run_txn(10, 20, 11, 10, 0, 0);
    run_txn(100, 250, 6, 10, 0, 0);
    run_txn(10 + FEE_M, 245, 10, 10, 0, 0);
    run_txn(40, 7, 0, 10, 0, 0);

    // Start held high past DONE must not retrigger.
    run_txn(60, 10, 5, 10, 1, 0);
    clear_obs();
    repeat (20) @(posedge clock);
    #1;
    check("hold_no_fin", n_fin, 0);
    check("hold_no_write", wq.size(), 0);
    check("hold_no_plot", pq.size(), 0);

    // Fresh edge during DRAW is ignored.
    run_txn(80, 30, 20, 10, 0, 1);

    // Reset in WAIT_FRAME.
    preload(50, 20);
    amount = 8'd30;
    key = 4'hA;
    start_animation = 1'b0;
    @(posedge clock);
    #1;
    start_animation = 1'b1;
    cyc = 0;
    while (!bus.plot && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    while (bus.plot && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("reach_wait_frame", 32'(cyc < 100), 1);
    reset = 1'b1;
    #1;
    outs_zero("async_reset_outs");
    start_animation = 1'b0;
    n_fin = 0;
    repeat (5) @(posedge clock);
    #1;
    check("reset_no_fin", n_fin, 0);
    check("reset_keep_p1", ram[0], 8'd20);
    check("reset_keep_p2", ram[1], 8'd50);
    reset = 1'b0;
    run_txn(50, 20, 30, 10, 0, 0);

`ifdef TXN_FEE_EN
    run_txn(30, 10, 30, 10, 0, 0);
    run_txn(31, 10, 30, 10, 0, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      b1 = int'($urandom_range(0, 255));
      b2 = int'($urandom_range(0, 255));
      a = int'($urandom_range(0, (b1 + 8 > 255) ? 255 : b1 + 8));
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 10;
      run_txn(b1, b2, a, k, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
